// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state types and BCD helper for the character LCD driver
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC  = 8'h38;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_L1    = 8'h80;
    localparam logic [7:0] CMD_L2    = 8'hC0;

    localparam logic [2:0] SCR_WELCOME = 3'd0;
    localparam logic [2:0] SCR_TYPE    = 3'd1;
    localparam logic [2:0] SCR_CONFIRM = 3'd2;
    localparam logic [2:0] SCR_DONE    = 3'd3;
    localparam logic [2:0] SCR_COUNTS  = 3'd4;
    localparam logic [2:0] SCR_WINNER  = 3'd5;
    localparam logic [2:0] SCR_TOTAL   = 3'd6;
    localparam logic [2:0] SCR_NULL    = 3'd7;

    // Sequencer steps: 0..3 init, then 0x80 + 16 chars + 0xC0 + 16 chars, looping to STEP_L1
    localparam logic [5:0] STEP_L1   = 6'd4;
    localparam logic [5:0] STEP_L2   = 6'd21;
    localparam logic [5:0] STEP_LAST = 6'd37;

    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_WAIT} writer_state_t;
    typedef enum logic {SEQ_PWRUP, SEQ_RUN} seq_state_t;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h2D;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// rtl/lcd_byte_writer.sv - one LCD bus transfer: SETUP, EN pulse, then settle wait
module lcd_byte_writer #(
    parameter int EN_CYCLES = 16,
    parameter int XFER_WAIT = 2_500,
    parameter int CLR_WAIT  = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       ready,
    output logic       done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);
    import lcd_pkg::*;

    writer_state_t state, state_next;
    logic [31:0]   cnt, cnt_next;
    logic          long_q;
    logic          load;
    logic [31:0]   wait_last;

    assign wait_last = long_q ? 32'(CLR_WAIT - 1) : 32'(XFER_WAIT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= W_IDLE;
            cnt      <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            long_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load) begin
                lcd_rs   <= rs;
                lcd_data <= data;
                long_q   <= long_wait;
            end
        end
    end

    // A start accepted on the final WAIT cycle chains straight into the next SETUP
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        done       = 1'b0;
        case (state)
            W_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = W_SETUP;
                end
            end
            W_SETUP: begin
                state_next = W_PULSE;
                cnt_next   = '0;
            end
            W_PULSE: begin
                if (cnt == 32'(EN_CYCLES - 1)) begin
                    state_next = W_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            W_WAIT: begin
                if (cnt == wait_last) begin
                    done     = 1'b1;
                    cnt_next = '0;
                    if (start) begin
                        load       = 1'b1;
                        state_next = W_SETUP;
                    end else begin
                        state_next = W_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            default: state_next = W_IDLE;
        endcase
    end

    assign ready  = (state == W_IDLE) || done;
    assign lcd_en = (state == W_PULSE);

endmodule

// File: rtl/lcd_content.sv
// rtl/lcd_content.sv - power-up, init and continuous screen refresh for the 16x2 voting-machine LCD
module lcd_content #(
    parameter int PWRUP_CYCLES = 1_000_000,
    parameter int EN_CYCLES    = 16,
    parameter int XFER_WAIT    = 2_500,
    parameter int CLR_WAIT     = 100_000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [2:0] estado,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic [3:0] c1Dez,
    input  logic [3:0] c1Uni,
    input  logic [3:0] c2Dez,
    input  logic [3:0] c2Uni,
    input  logic [3:0] c3Dez,
    input  logic [3:0] c3Uni,
    input  logic [3:0] c4Dez,
    input  logic [3:0] c4Uni,
    input  logic [3:0] tDez,
    input  logic [3:0] tUni,
    input  logic [3:0] nDez,
    input  logic [3:0] nUni,
    input  logic [3:0] cadVencedr1,
    input  logic [3:0] cadVencedr2,
    inout  wire  [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);
    import lcd_pkg::*;

    seq_state_t  seq_state, seq_next;
    logic [31:0] pwr_cnt, pwr_next;
    logic [5:0]  step, step_next;
    logic        start, ready, done;
    logic        byte_rs, long_wait;
    logic [7:0]  byte_data, ch, data_out;
    logic        line2, tie, pair_en;
    logic [3:0]  col, pair_col, tens, units;
    logic [127:0] tmpl;

    // Digit positions are blank here and overlaid from the live BCD inputs
    function automatic logic [127:0] screen_line(input logic [2:0] scr, input logic l2,
                                                 input logic is_tie);
        logic [127:0] t;
        t = "                ";
        case (scr)
            SCR_WELCOME: t = l2 ? "KEY0 P/ VOTAR   " : "URNA ELETRONICA ";
            SCR_TYPE:    t = l2 ? "CANDIDATO:      " : "DIGITE O NUMERO ";
            SCR_CONFIRM: t = l2 ? "NUMERO:         " : "CONFIRMA VOTO?  ";
            SCR_DONE:    t = l2 ? "OBRIGADO        " : "VOTO CONFIRMADO ";
            SCR_COUNTS:  t = l2 ? "C17:    C51:    " : "C12:    C13:    ";
            SCR_WINNER:  t = !l2 ? "VENCEDOR:       " :
                             (is_tie ? "EMPATE          " : "CANDIDATO       ");
            SCR_TOTAL:   t = l2 ? "TOTAL:          " : "TOTAL DE VOTOS  ";
            SCR_NULL:    t = l2 ? "NULOS:          " : "VOTOS NULOS     ";
            default:     t = "                ";
        endcase
        return t;
    endfunction

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            seq_state <= SEQ_PWRUP;
            pwr_cnt   <= '0;
            step      <= '0;
        end else begin
            seq_state <= seq_next;
            pwr_cnt   <= pwr_next;
            step      <= step_next;
        end
    end

    always_comb begin
        seq_next  = seq_state;
        pwr_next  = pwr_cnt;
        step_next = step;
        start     = 1'b0;
        case (seq_state)
            SEQ_PWRUP: begin
                if (pwr_cnt == 32'(PWRUP_CYCLES - 1)) begin
                    seq_next = SEQ_RUN;
                    pwr_next = '0;
                end else begin
                    pwr_next = pwr_cnt + 32'd1;
                end
            end
            SEQ_RUN: begin
                if (ready) begin
                    start     = 1'b1;
                    step_next = (step == STEP_LAST) ? STEP_L1 : step + 6'd1;
                end
            end
            default: seq_next = SEQ_PWRUP;
        endcase
    end

    always_comb begin
        line2    = (step > STEP_L2);
        col      = line2 ? 4'(step - 6'd22) : 4'(step - 6'd5);
        tie      = (cadVencedr1 == 4'd8) && (cadVencedr2 == 4'd8);
        tmpl     = screen_line(estado, line2, tie);
        ch       = tmpl[{~col, 3'b000} +: 8];
        pair_en  = 1'b0;
        pair_col = 4'd0;
        tens     = 4'd0;
        units    = 4'd0;
        case (estado)
            SCR_TYPE, SCR_CONFIRM: begin
                pair_en  = line2;
                pair_col = (estado == SCR_TYPE) ? 4'd11 : 4'd8;
                tens     = bcd2;
                units    = bcd1;
            end
            SCR_COUNTS: begin
                pair_en  = 1'b1;
                pair_col = col[3] ? 4'd12 : 4'd4;
                if (!line2) begin
                    tens  = col[3] ? c2Dez : c1Dez;
                    units = col[3] ? c2Uni : c1Uni;
                end else begin
                    tens  = col[3] ? c4Dez : c3Dez;
                    units = col[3] ? c4Uni : c3Uni;
                end
            end
            SCR_WINNER: begin
                pair_en  = line2 && !tie;
                pair_col = 4'd10;
                tens     = cadVencedr1;
                units    = cadVencedr2;
            end
            SCR_TOTAL: begin
                pair_en  = line2;
                pair_col = 4'd7;
                tens     = tDez;
                units    = tUni;
            end
            SCR_NULL: begin
                pair_en  = line2;
                pair_col = 4'd7;
                tens     = nDez;
                units    = nUni;
            end
            default: pair_en = 1'b0;
        endcase
        if (pair_en && col == pair_col) begin
            ch = bcd_to_ascii(tens);
        end else if (pair_en && col == pair_col + 4'd1) begin
            ch = bcd_to_ascii(units);
        end
    end

    always_comb begin
        byte_rs   = 1'b0;
        long_wait = 1'b0;
        byte_data = ch;
        case (step)
            6'd0:    byte_data = CMD_FUNC;
            6'd1:    byte_data = CMD_DISP;
            6'd2: begin
                byte_data = CMD_CLR;
                long_wait = 1'b1;
            end
            6'd3:    byte_data = CMD_ENTRY;
            STEP_L1: byte_data = CMD_L1;
            STEP_L2: byte_data = CMD_L2;
            default: byte_rs   = 1'b1;
        endcase
    end

    lcd_byte_writer #(
        .EN_CYCLES (EN_CYCLES),
        .XFER_WAIT (XFER_WAIT),
        .CLR_WAIT  (CLR_WAIT)
    ) u_writer (
        .clk       (iCLK),
        .rst       (iRST),
        .start     (start),
        .rs        (byte_rs),
        .data      (byte_data),
        .long_wait (long_wait),
        .ready     (ready),
        .done      (done),
        .lcd_en    (LCD_EN),
        .lcd_rs    (LCD_RS),
        .lcd_data  (data_out)
    );

    assign LCD_DATA = data_out;
    assign LCD_RW   = 1'b0;

    logic unused_done;
    assign unused_done = done;

endmodule

// File: tb/tb_lcd_content.sv
// tb/tb_lcd_content.sv - scoreboard bench for lcd_content with a string-level screen model
module tb_lcd_content;

    localparam int PWR = 20;
    localparam int ENC = 2;
    localparam int XW  = 4;
    localparam int CW  = 8;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [2:0] estado;
    logic [3:0] bcd1, bcd2, c1Dez, c1Uni, c2Dez, c2Uni, c3Dez, c3Uni, c4Dez, c4Uni;
    logic [3:0] tDez, tUni, nDez, nUni, cadVencedr1, cadVencedr2;
    wire  [7:0] lcd_data;
    logic       LCD_RW, LCD_EN, LCD_RS;

    lcd_content #(
        .PWRUP_CYCLES (PWR),
        .EN_CYCLES    (ENC),
        .XFER_WAIT    (XW),
        .CLR_WAIT     (CW)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .estado      (estado),
        .bcd1        (bcd1),
        .bcd2        (bcd2),
        .c1Dez       (c1Dez),
        .c1Uni       (c1Uni),
        .c2Dez       (c2Dez),
        .c2Uni       (c2Uni),
        .c3Dez       (c3Dez),
        .c3Uni       (c3Uni),
        .c4Dez       (c4Dez),
        .c4Uni       (c4Uni),
        .tDez        (tDez),
        .tUni        (tUni),
        .nDez        (nDez),
        .nUni        (nUni),
        .cadVencedr1 (cadVencedr1),
        .cadVencedr2 (cadVencedr2),
        .LCD_DATA    (lcd_data),
        .LCD_RW      (LCD_RW),
        .LCD_EN      (LCD_EN),
        .LCD_RS      (LCD_RS)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [2:0] scr;
        logic [3:0] b2, b1, c1d, c1u, c2d, c2u, c3d, c3u, c4d, c4u, td, tu, nd, nu, v1, v2;
    } cfg_t;

    logic [8:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int rx_count = 0;
    int rx_base = 0;
    int npass = 0;

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0h required %0h", name, got, want);
    endtask

    function automatic string dig(input logic [3:0] d);
        if (d < 10) return $sformatf("%0d", d);
        return "-";
    endfunction

    function automatic string line_text(input cfg_t c, input int ln);
        case (c.scr)
            3'd0: if (ln == 0) return "URNA ELETRONICA "; else return "KEY0 P/ VOTAR   ";
            3'd1: if (ln == 0) return "DIGITE O NUMERO ";
                  else return $sformatf("CANDIDATO: %s%s   ", dig(c.b2), dig(c.b1));
            3'd2: if (ln == 0) return "CONFIRMA VOTO?  ";
                  else return $sformatf("NUMERO: %s%s      ", dig(c.b2), dig(c.b1));
            3'd3: if (ln == 0) return "VOTO CONFIRMADO "; else return "OBRIGADO        ";
            3'd4: if (ln == 0) return $sformatf("C12:%s%s  C13:%s%s  ",
                                                dig(c.c1d), dig(c.c1u), dig(c.c2d), dig(c.c2u));
                  else return $sformatf("C17:%s%s  C51:%s%s  ",
                                        dig(c.c3d), dig(c.c3u), dig(c.c4d), dig(c.c4u));
            3'd5: if (ln == 0) return "VENCEDOR:       ";
                  else if (c.v1 == 8 && c.v2 == 8) return "EMPATE          ";
                  else return $sformatf("CANDIDATO %s%s    ", dig(c.v1), dig(c.v2));
            3'd6: if (ln == 0) return "TOTAL DE VOTOS  ";
                  else return $sformatf("TOTAL: %s%s       ", dig(c.td), dig(c.tu));
            default: if (ln == 0) return "VOTOS NULOS     ";
                  else return $sformatf("NULOS: %s%s       ", dig(c.nd), dig(c.nu));
        endcase
    endfunction

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic push_pass(input cfg_t c);
        string s;
        for (int ln = 0; ln < 2; ln++) begin
            s = line_text(c, ln);
            exp_q.push_back({1'b0, (ln == 0) ? 8'h80 : 8'hC0});
            for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, s.getc(i)});
        end
    endtask

    task automatic apply(input cfg_t c);
        estado = c.scr; bcd2 = c.b2; bcd1 = c.b1;
        c1Dez = c.c1d; c1Uni = c.c1u; c2Dez = c.c2d; c2Uni = c.c2u;
        c3Dez = c.c3d; c3Uni = c.c3u; c4Dez = c.c4d; c4Uni = c.c4u;
        tDez = c.td; tUni = c.tu; nDez = c.nd; nUni = c.nu;
        cadVencedr1 = c.v1; cadVencedr2 = c.v2;
    endtask

    task automatic wait_rx(input int target);
        int n = 0;
        while (rx_count < target && n < 3000) begin
            @(negedge iCLK);
            n++;
        end
        if (rx_count < target) begin
            checks++;
            $display("FAIL wait_rx: got %0d bytes required %0d", rx_count, target);
        end
        #1;
    endtask

    // Waits for the previous pass to end, then changes inputs and queues the next pass
    task automatic next_pass(input cfg_t c);
        wait_rx(rx_base + 4 + 34 * npass);
        apply(c);
        push_pass(c);
        npass++;
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c = cfg_t'({$urandom, $urandom});
        c.scr = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) begin
            c.v1 = 4'd8;
            c.v2 = 4'd8;
        end
        return c;
    endfunction

    // Monitor: captures each byte on EN rise, checks pulse width, hold and inter-pulse gaps
    initial begin : monitor
        logic       in_pulse, seen_first, last_clr;
        int         width, low_cnt;
        logic [8:0] got, held, want;
        in_pulse = 0; seen_first = 0; last_clr = 0; width = 0; low_cnt = 0; held = '0;
        forever begin
            @(negedge iCLK);
            got = {LCD_RS, lcd_data};
            if (iRST) begin
                in_pulse = 0; seen_first = 0; last_clr = 0; low_cnt = 0;
            end else if (LCD_EN) begin
                if (!in_pulse) begin
                    if (!seen_first) begin
                        checks++;
                        if (low_cnt >= PWR && low_cnt <= PWR + 3) passes++;
                        else $display("FAIL pwrup_wait: got %0d low cycles required %0d..%0d",
                                      low_cnt, PWR, PWR + 3);
                    end else begin
                        check("gap", low_cnt, last_clr ? CW + 1 : XW + 1);
                    end
                    seen_first = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL byte%0d: got %h required nothing queued", rx_count, got);
                    end else begin
                        want = exp_q.pop_front();
                        check($sformatf("byte%0d", rx_count), got, want);
                    end
                    last_clr = (got == 9'h001);
                    in_pulse = 1;
                    width = 1;
                    held = got;
                    rx_count++;
                end else begin
                    width++;
                    check("hold", got, held);
                end
            end else begin
                if (in_pulse) begin
                    check("en_width", width, ENC);
                    in_pulse = 0;
                    low_cnt = 1;
                end else begin
                    low_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        cfg_t c;
        int   n;
        c = '0;
        apply(c);
        iRST = 1'b1;
        repeat (5) @(posedge iCLK);
        #1;
        check("rst_en", LCD_EN, 0);
        check("rst_rs", LCD_RS, 0);
        check("rst_data", lcd_data, 0);
        check("rst_rw", LCD_RW, 0);
        push_init();
        push_pass(c);
        npass = 1;
        @(negedge iCLK);
        #1 iRST = 1'b0;

        c = '0; c.scr = 3'd1; c.b2 = 4'd1; c.b1 = 4'd2;
        next_pass(c);
        // bcd1 changes after line-2 column 12 is sent: this pass shows 12, the next 17
        wait_rx(rx_base + 4 + 34 * (npass - 1) + 31);
        bcd1 = 4'd7;
        c.b1 = 4'd7;
        next_pass(c);

        c = '0; c.scr = 3'd4; c.c1u = 4'd3; c.c2d = 4'd1; c.c4u = 4'd9;
        next_pass(c);
        c = '0; c.scr = 3'd5; c.v1 = 4'd5; c.v2 = 4'd1;
        next_pass(c);
        c.v1 = 4'd8; c.v2 = 4'd8;
        next_pass(c);
        c = '0; c.scr = 3'd7; c.nd = 4'd1; c.nu = 4'd4;
        next_pass(c);

        for (int k = 0; k < 10; k++) next_pass(rand_cfg());
        next_pass(c);

        // Reset while EN is high in the middle of a refresh pass
        wait_rx(rx_base + 4 + 34 * (npass - 1) + 10);
        n = 0;
        while (n < 50) begin
            @(negedge iCLK);
            if (LCD_EN) break;
            n++;
        end
        check("en_seen_before_reset", LCD_EN, 1);
        #1 iRST = 1'b1;
        @(posedge iCLK);
        #1;
        check("midrst_en", LCD_EN, 0);
        check("midrst_data", lcd_data, 0);
        repeat (3) @(posedge iCLK);
        #1;
        exp_q.delete();
        rx_base = rx_count;
        c = rand_cfg();
        apply(c);
        push_init();
        push_pass(c);
        npass = 1;
        @(negedge iCLK);
        #1 iRST = 1'b0;
        next_pass(rand_cfg());
        wait_rx(rx_base + 4 + 34 * npass);
        check("queue_drained", exp_q.size(), 0);
        iRST = 1'b1;
        repeat (3) @(posedge iCLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
